// File: rtl/axis_adc_dec4.sv
`default_nettype none
// ============================================================================
//  Module   : axis_adc_dec4
//  Purpose  : Fixed 4:1 boxcar decimator for the raw ADC stream. It sums four
//             consecutive signed ADC samples into one signed word that is two
//             bits wider, so the sum can never overflow. It also exports the
//             slot index that downstream stages use for 0/90/180/270
//             alignment.
//  Ports    : aclk, areset      - clock (rising edge), async active-high reset
//             S_AXIS_tdata/tvalid/tready - raw ADC input; tready is always 1
//             dec_sync          - realign strobe: drops the partial sum and
//                                 restarts the slot count
//             overrange_clear   - clears the sticky overrange flag
//             M_AXIS_tdata/tvalid - decimated sum, tvalid is a 1-cycle pulse
//             phase             - slot the next accepted sample will occupy
//             overrange         - sticky flag for full-scale ADC codes
//  Config   : define ADC_DEC_OVERRANGE_EN to build the overrange detector;
//             without it, overrange is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_adc_dec4 #(
    parameter int ADC_DATA_WIDTH    = 14,
    parameter int S_AXIS_DATA_WIDTH = 16,
    parameter int M_AXIS_DATA_WIDTH = 16
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [S_AXIS_DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic                         S_AXIS_tvalid,
    output logic                         S_AXIS_tready,
    input  logic                         dec_sync,
    input  logic                         overrange_clear,
    output logic [M_AXIS_DATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                         M_AXIS_tvalid,
    output logic [1:0]                   phase,
    output logic                         overrange
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } phase_t;

    phase_t                        phase_q;
    logic [M_AXIS_DATA_WIDTH-1:0]  acc_q;
    logic [M_AXIS_DATA_WIDTH-1:0]  m_tdata_q;
    logic                          m_tvalid_q;

    logic [ADC_DATA_WIDTH-1:0]     raw_w;
    logic [M_AXIS_DATA_WIDTH-1:0]  x_w;
    logic [M_AXIS_DATA_WIDTH-1:0]  sum_d;

    // Upper bus bits carry no sample information.
    assign raw_w = S_AXIS_tdata[ADC_DATA_WIDTH-1:0];
    assign x_w   = {{(M_AXIS_DATA_WIDTH-ADC_DATA_WIDTH){raw_w[ADC_DATA_WIDTH-1]}}, raw_w};
    // Two's-complement add; width is ADC+2 so four samples never wrap.
    assign sum_d = acc_q + x_w;

    generate
        if (S_AXIS_DATA_WIDTH > ADC_DATA_WIDTH) begin : g_upper_bits
            wire unused_upper_w = &{1'b0, S_AXIS_tdata[S_AXIS_DATA_WIDTH-1:ADC_DATA_WIDTH]};
        end
    endgenerate

    // Slot counter, accumulator and output register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            phase_q    <= S0;
            acc_q      <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            m_tvalid_q <= 1'b0;
            if (dec_sync) begin
                // Partial sum is dropped without producing an output, even
                // from S3; a simultaneous sample opens the new group.
                if (S_AXIS_tvalid) begin
                    acc_q   <= x_w;
                    phase_q <= S1;
                end else begin
                    acc_q   <= '0;
                    phase_q <= S0;
                end
            end else if (S_AXIS_tvalid) begin
                case (phase_q)
                    S0: begin
                        acc_q   <= x_w;
                        phase_q <= S1;
                    end
                    S1: begin
                        acc_q   <= sum_d;
                        phase_q <= S2;
                    end
                    S2: begin
                        acc_q   <= sum_d;
                        phase_q <= S3;
                    end
                    S3: begin
                        acc_q      <= sum_d;
                        m_tdata_q  <= sum_d;
                        m_tvalid_q <= 1'b1;
                        phase_q    <= S0;
                    end
                    default: begin
                        acc_q   <= '0;
                        phase_q <= S0;
                    end
                endcase
            end
        end
    end

`ifdef ADC_DEC_OVERRANGE_EN
    localparam logic [ADC_DATA_WIDTH-1:0] MAX_CODE = {1'b0, {(ADC_DATA_WIDTH-1){1'b1}}};
    localparam logic [ADC_DATA_WIDTH-1:0] MIN_CODE = {1'b1, {(ADC_DATA_WIDTH-1){1'b0}}};

    logic overrange_q;
    logic hit_w;

    assign hit_w = S_AXIS_tvalid && ((raw_w == MAX_CODE) || (raw_w == MIN_CODE));

    // Set has priority over clear so a clipped sample is never lost.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            overrange_q <= 1'b0;
        end else if (hit_w) begin
            overrange_q <= 1'b1;
        end else if (overrange_clear) begin
            overrange_q <= 1'b0;
        end
    end

    assign overrange = overrange_q;
`else
    wire unused_clear_w = overrange_clear;
    assign overrange = 1'b0;
`endif

    assign S_AXIS_tready = 1'b1;
    assign M_AXIS_tdata  = m_tdata_q;
    assign M_AXIS_tvalid = m_tvalid_q;
    assign phase         = phase_q;

endmodule
`default_nettype wire
